// File: rtl/spi_cmd_pkg.sv
// Shared types and helpers for the SPI command decoder / register file.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    TX_WAIT   = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int CMD_WR_BIT  = DEF_DATA_W - 1;
  localparam int STATUS_ADDR = (1 << DEF_ADDR_W) - 1;

  // A command is legal only when every bit between the write flag and the address is zero.
  function automatic logic cmd_valid(input logic [31:0] cmd, input int data_w, input int addr_w);
    logic [31:0] mask;
    mask = ((32'd1 << (data_w - 1)) - 32'd1) & ~((32'd1 << addr_w) - 32'd1);
    return (cmd & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/spi_cmd_regfile.sv
// Control register array: one write port, one combinational read port, register 0 tap.
// The top address is STATUS and has no storage here; it reads back as zero.
module spi_cmd_regfile
  import spi_cmd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] reg0
);

  localparam int NREG = (1 << ADDR_W) - 1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (we && (waddr == ADDR_W'(i))) begin
        regs_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rdata = regs_q[i];
      end
    end
  end

  assign reg0 = regs_q[0];

endmodule

// File: rtl/spi_cmd_regs.sv
// Byte-level SPI command decoder: 1-byte commands (MSB=1 write, MSB=0 read) over a small register file.
// Optional build macro SPI_CMD_AUTOINC_EN: write commands become bursts with address auto-increment.
module spi_cmd_regs
  import spi_cmd_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] ctrl_out,
  output logic              busy,
  output logic              err
);

  localparam int                TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]     TMAX     = TW'(TIMEOUT_CYC);
  localparam int                WR_BIT   = DATA_W - 1;
  localparam logic [ADDR_W-1:0] STATUS_A = '1;

`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d;
  logic              got_q, got_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic              cmd_ok, cmd_wr, decode, timeout;
  logic              err_set, err_clr, wr_en;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] rd_data;

  assign cmd_ok   = cmd_valid(32'(rx_data), DATA_W, ADDR_W);
  assign cmd_wr   = rx_data[WR_BIT];
  assign cmd_addr = rx_data[ADDR_W-1:0];
  // A byte arriving together with tx_done is treated as a fresh command.
  assign decode   = rx_valid && ((state_q == IDLE) || ((state_q == TX_WAIT) && tx_done));
  assign timeout  = (state_q == WAIT_DATA) && !rx_valid && (timer_q == TMAX);

  spi_cmd_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (addr_q),
    .wdata (rx_data),
    .raddr (cmd_addr),
    .rdata (rd_data),
    .reg0  (ctrl_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      got_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      got_q      <= got_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (decode) begin
      if (!cmd_ok)     state_d = IDLE;
      else if (cmd_wr) state_d = WAIT_DATA;
      else             state_d = TX_WAIT;
    end else begin
      case (state_q)
        WAIT_DATA: begin
          if (rx_valid)     state_d = AUTOINC ? WAIT_DATA : IDLE;
          else if (timeout) state_d = IDLE;
        end
        TX_WAIT: begin
          if (tx_done) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_d     = addr_q;
    timer_d    = timer_q;
    got_d      = got_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    wr_en      = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;

    if (decode) begin
      if (!cmd_ok) begin
        err_set = 1'b1;
      end else if (cmd_wr) begin
        addr_d  = cmd_addr;
        timer_d = '0;
        got_d   = 1'b0;
      end else begin
        tx_data_d  = (cmd_addr == STATUS_A) ? status_in : rd_data;
        tx_start_d = 1'b1;
      end
    end

    case (state_q)
      WAIT_DATA: begin
        timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
        if (rx_valid) begin
          if (addr_q == STATUS_A) err_clr = 1'b1;
          else                    wr_en   = 1'b1;
          if (AUTOINC) begin
            addr_d  = addr_q + ADDR_W'(1);
            timer_d = '0;
            got_d   = 1'b1;
          end
        end else if (timeout && !(AUTOINC && got_q)) begin
          err_set = 1'b1;
        end
      end
      TX_WAIT: begin
        if (rx_valid && !tx_done) err_set = 1'b1;
      end
      default: ;
    endcase

    // Clearing takes priority over a coincident set.
    err_d = err_clr ? 1'b0 : (err_set ? 1'b1 : err_q);
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Self-checking bench for spi_cmd_regs: directed protocol cases plus randomized register traffic
// checked against a register-array model. Also covers the SPI_CMD_AUTOINC_EN build.
module tb_spi_cmd_regs;
  import spi_cmd_pkg::*;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 3;
  localparam int TIMEOUT_CYC = 255;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_done;
  logic [DATA_W-1:0] status_in;
  logic [DATA_W-1:0] ctrl_out;
  logic              busy;
  logic              err;

  spi_cmd_regs #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .status_in (status_in),
    .ctrl_out  (ctrl_out),
    .busy      (busy),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: register contents and the sticky error flag
  logic [DATA_W-1:0] mdl_regs [2**ADDR_W];
  logic              mdl_err;
  logic [DATA_W-1:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**ADDR_W; i++) mdl_regs[i] = '0;
    mdl_err = 1'b0;
  endtask

  // driver tasks: each starts and ends at a falling edge
  task automatic send_byte(input logic [DATA_W-1:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    send_byte(8'(1 << CMD_WR_BIT) | 8'(a));
    check_eq("wr_busy", busy, 1);
    send_byte(d);
    if (a == STATUS_ADDR) mdl_err = 1'b0;
    else                  mdl_regs[a] = d;
    check_eq("wr_ctrl", ctrl_out, mdl_regs[0]);
    check_eq("wr_err", err, mdl_err);
`ifdef SPI_CMD_AUTOINC_EN
    check_eq("wr_burst_busy", busy, 1);
    repeat (TIMEOUT_CYC + 1) tick();
`endif
    check_eq("wr_idle", busy, 0);
  endtask

  task automatic do_read(input int a);
    logic [DATA_W-1:0] exp;
    int gap;
    exp = (a == STATUS_ADDR) ? status_in : mdl_regs[a];
    exp_q.push_back(exp);
    send_byte(8'(a));
    check_eq("rd_start", tx_start, 1);
    check_eq("rd_data", tx_data, exp_q.pop_front());
    status_in = $urandom;
    gap = $urandom_range(1, 4);
    repeat (gap) tick();
    check_eq("rd_start_once", tx_start, 0);
    check_eq("rd_data_held", tx_data, exp);
    check_eq("rd_busy", busy, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("rd_done_idle", busy, 0);
  endtask

  task automatic bad_cmd();
    logic [DATA_W-1:0] c;
    c = 8'(($urandom_range(0, 1) << CMD_WR_BIT) | ($urandom_range(1, 15) << ADDR_W) | $urandom_range(0, 7));
    send_byte(c);
    mdl_err = 1'b1;
    check_eq("bad_err", err, 1);
    check_eq("bad_idle", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    tx_done   = 1'b0;
    status_in = '0;
    model_reset();
    tick();
    tick();
    check_eq("rst_ctrl", ctrl_out, 0);
    check_eq("rst_txd", tx_data, 0);
    check_eq("rst_txs", tx_start, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // basic write / read-back
    do_write(0, 8'h5A);
    check_eq("ctrl_5a", ctrl_out, 8'h5A);
    do_read(0);

    // STATUS read samples status_in in the command cycle
    status_in = 8'hC3;
    do_read(STATUS_ADDR);

    // illegal command, then error clear through STATUS write
    send_byte(8'h90);
    mdl_err = 1'b1;
    check_eq("err_90", err, 1);
    do_write(STATUS_ADDR, 8'h00);
    check_eq("err_clr", err, 0);

    // tx_done while idle has no effect
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("stray_done_busy", busy, 0);
    check_eq("stray_done_start", tx_start, 0);

    // write command with no data byte times out
    send_byte(8'h81);
    repeat (TIMEOUT_CYC) tick();
    check_eq("to_not_yet_busy", busy, 1);
    check_eq("to_not_yet_err", err, 0);
    tick();
    mdl_err = 1'b1;
    check_eq("to_err", err, 1);
    check_eq("to_idle", busy, 0);
    do_read(1);

    // byte during TX_WAIT without tx_done, then back-to-back command with tx_done
    do_write(2, 8'hA5);
    do_write(STATUS_ADDR, 8'h00);
    send_byte(8'h01);
    check_eq("tw_start", tx_start, 1);
    send_byte(8'h01);
    mdl_err = 1'b1;
    check_eq("tw_err", err, 1);
    check_eq("tw_busy", busy, 1);
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    tx_done  = 1'b1;
    tick();
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    check_eq("b2b_start", tx_start, 1);
    check_eq("b2b_data", tx_data, mdl_regs[2]);
    check_eq("b2b_busy", busy, 1);
    tick();
    check_eq("b2b_start_once", tx_start, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("b2b_idle", busy, 0);
    check_eq("b2b_err_sticky", err, 1);

`ifdef SPI_CMD_AUTOINC_EN
    // burst: reg6, STATUS (clears err), reg0 after address wrap
    send_byte(8'h86);
    send_byte(8'h11);
    send_byte(8'hEE);
    send_byte(8'h22);
    mdl_regs[6] = 8'h11;
    mdl_regs[0] = 8'h22;
    mdl_err     = 1'b0;
    check_eq("ai_ctrl", ctrl_out, 8'h22);
    check_eq("ai_err_clr", err, 0);
    check_eq("ai_busy", busy, 1);
    repeat (TIMEOUT_CYC + 1) tick();
    check_eq("ai_silent_end", busy, 0);
    check_eq("ai_no_err", err, 0);
    do_read(6);
`endif

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 4);
      status_in = $urandom;
      case (op)
        0, 1:    do_write($urandom_range(0, 2**ADDR_W - 1), 8'($urandom));
        2, 3:    do_read($urandom_range(0, 2**ADDR_W - 1));
        default: bad_cmd();
      endcase
      check_eq("rnd_err", err, mdl_err);
      repeat ($urandom_range(0, 3)) tick();
    end

    // asynchronous reset in the middle of WAIT_DATA
    do_write(0, 8'hFF);
    do_read(0);
    bad_cmd();
    send_byte(8'h83);
    check_eq("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_ctrl", ctrl_out, 0);
    check_eq("arst_txd", tx_data, 0);
    check_eq("arst_txs", tx_start, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_err", err, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    do_read(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
